// File: rtl/sram_cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate cache between the memory stage
// and the SRAM controller. Read hits complete in the request cycle; misses and stores stall.
module sram_cache_controller #(
  parameter int unsigned SETS  = 64,
  parameter int unsigned TAG_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int unsigned IdxW = $clog2(SETS);

  typedef enum logic [1:0] {StIdle, StRdMiss, StWrThru} state_e;

  state_e state_q, state_d;

  logic [SETS-1:0]  valid0_q, valid0_d, valid1_q, valid1_d;
  logic [SETS-1:0]  lru_q, lru_d;
  logic [TAG_W-1:0] tag0_q  [SETS];
  logic [TAG_W-1:0] tag1_q  [SETS];
  logic [63:0]      line0_q [SETS];
  logic [63:0]      line1_q [SETS];

  logic [IdxW-1:0]  idx;
  logic [TAG_W-1:0] tag;
  logic             word_sel;
  logic             hit0, hit1, hit;
  logic [63:0]      hit_line;
  logic             fill_way;
  logic [1:0]       line_we;
  logic [1:0]       tag_we;
  logic [63:0]      line_wd;
  logic             unused_addr;

  assign word_sel     = address[2];
  assign idx          = address[3 +: IdxW];
  assign tag          = address[3 + IdxW +: TAG_W];
  assign unused_addr  = ^{address[31:3 + IdxW + TAG_W], address[1:0]};
  assign sram_address = address;
  assign sram_wdata   = wdata;

  // Fills only happen on a miss, so a tag can never be present in both ways.
  assign hit0     = valid0_q[idx] && (tag0_q[idx] == tag);
  assign hit1     = valid1_q[idx] && (tag1_q[idx] == tag);
  assign hit      = hit0 || hit1;
  assign hit_line = hit0 ? line0_q[idx] : line1_q[idx];
  assign fill_way = !valid0_q[idx] ? 1'b0 : (!valid1_q[idx] ? 1'b1 : lru_q[idx]);

  always_comb begin
    state_d    = state_q;
    valid0_d   = valid0_q;
    valid1_d   = valid1_q;
    lru_d      = lru_q;
    ready      = 1'b1;
    rdata      = '0;
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    line_we    = 2'b00;
    tag_we     = 2'b00;
    line_wd    = sram_rdata;

    unique case (state_q)
      StIdle: begin
        if (MEM_W_EN) begin
          ready   = 1'b0;
          state_d = StWrThru;
        end else if (MEM_R_EN) begin
          if (hit) begin
            rdata      = word_sel ? hit_line[63:32] : hit_line[31:0];
            lru_d[idx] = hit0;
          end else begin
            ready   = 1'b0;
            state_d = StRdMiss;
          end
        end
      end
      StRdMiss: begin
        sram_rd_en = 1'b1;
        ready      = sram_ready;
        if (sram_ready) begin
          rdata      = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
          line_we    = fill_way ? 2'b10 : 2'b01;
          tag_we     = line_we;
          lru_d[idx] = ~fill_way;
          if (fill_way) valid1_d[idx] = 1'b1;
          else          valid0_d[idx] = 1'b1;
          state_d    = StIdle;
        end
      end
      StWrThru: begin
        sram_wr_en = 1'b1;
        ready      = sram_ready;
        if (sram_ready) begin
          state_d = StIdle;
          if (hit) begin
            line_wd = hit_line;
            if (word_sel) line_wd[63:32] = wdata;
            else          line_wd[31:0]  = wdata;
            line_we    = hit1 ? 2'b10 : 2'b01;
            lru_d[idx] = hit0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      lru_q    <= lru_d;
    end
  end

  // Line and tag storage is not reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (line_we[0]) line0_q[idx] <= line_wd;
    if (line_we[1]) line1_q[idx] <= line_wd;
    if (tag_we[0])  tag0_q[idx]  <= tag;
    if (tag_we[1])  tag1_q[idx]  <= tag;
  end

endmodule

// File: tb/tb_sram_cache_controller.sv
// Randomized self-checking bench: a transaction-level cache model predicts every output cycle.
module tb_sram_cache_controller;

  localparam int unsigned SETS  = 64;
  localparam int unsigned TAG_W = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] address, wdata, rdata, sram_address, sram_wdata;
  logic        ready, sram_rd_en, sram_wr_en, sram_ready;
  logic [63:0] sram_rdata;

  always #5 clk = ~clk;

  sram_cache_controller #(.SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_rd_en   (sram_rd_en),
    .sram_wr_en   (sram_wr_en),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: cache contents plus a word-addressed backing memory.
  bit               mvalid [SETS][2];
  logic [TAG_W-1:0] mtag   [SETS][2];
  logic [63:0]      mdata  [SETS][2];
  bit               mlru   [SETS];
  logic [31:0]      mem    [logic [31:0]];

  logic        chk_en = 1'b0;
  logic        exp_ready, exp_rd_en, exp_wr_en;
  logic [31:0] exp_rdata;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", ready, exp_ready);
      check("sram_rd_en", sram_rd_en, exp_rd_en);
      check("sram_wr_en", sram_wr_en, exp_wr_en);
      check("rdata", rdata, exp_rdata);
      check("sram_address", sram_address, address);
      check("sram_wdata", sram_wdata, wdata);
    end
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  function automatic logic [31:0] pick(input logic [63:0] line, input logic w);
    return w ? line[63:32] : line[31:0];
  endfunction

  function automatic logic [63:0] junk();
    return {$urandom(), $urandom()};
  endfunction

  function automatic int lookup(input int s, input logic [TAG_W-1:0] t);
    for (int w = 0; w < 2; w++) if (mvalid[s][w] && mtag[s][w] == t) return w;
    return -1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      mvalid[s][0] = 1'b0;
      mvalid[s][1] = 1'b0;
      mlru[s]      = 1'b0;
    end
  endtask

  // One clock cycle: publish expectations, sample DUT mid-cycle, advance to posedge+1.
  task automatic cyc_step(input logic er, input logic erd, input logic ewr, input logic [31:0] edata,
                          input logic sr, input logic [63:0] srd,
                          output logic gr, output logic [31:0] gd);
    exp_ready  = er;
    exp_rd_en  = erd;
    exp_wr_en  = ewr;
    exp_rdata  = edata;
    sram_ready = sr;
    sram_rdata = srd;
    chk_en     = 1'b1;
    @(negedge clk);
    gr = ready;
    gd = rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    logic gr;
    logic [31:0] gd;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    cyc_step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, junk(), gr, gd);
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input int lat, output int cycles, output logic [31:0] got, output bit mhit);
    int s, way;
    logic [TAG_W-1:0] t;
    logic [31:0] blk;
    logic [63:0] line;
    logic gr, last;
    logic [31:0] gd;
    s = int'(a[8:3]);
    t = a[18:9];
    way = lookup(s, t);
    mhit = (way >= 0);
    MEM_R_EN = rd;
    MEM_W_EN = wr;
    address = a;
    wdata = wd;
    cycles = 0;
    got = '0;
    if (wr) begin
      cyc_step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, junk(), gr, gd);
      if (!gr) cycles++;
      for (int c = 1; c <= lat; c++) begin
        last = (c == lat);
        cyc_step(last, 1'b0, 1'b1, 32'h0, last, junk(), gr, gd);
        if (!gr) cycles++;
      end
      mem[{a[31:2], 2'b00}] = wd;
      if (mhit) begin
        line = mdata[s][way];
        if (a[2]) line[63:32] = wd;
        else      line[31:0]  = wd;
        mdata[s][way] = line;
        mlru[s] = (way == 0);
      end
    end else if (mhit) begin
      cyc_step(1'b1, 1'b0, 1'b0, pick(mdata[s][way], a[2]), 1'b0, junk(), gr, gd);
      if (!gr) cycles++;
      else got = gd;
      mlru[s] = (way == 0);
    end else begin
      blk  = {a[31:3], 3'b000};
      line = {mem_word(blk | 32'h4), mem_word(blk)};
      cyc_step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, junk(), gr, gd);
      if (!gr) cycles++;
      for (int c = 1; c <= lat; c++) begin
        last = (c == lat);
        cyc_step(last, 1'b1, 1'b0, last ? pick(line, a[2]) : 32'h0, last, last ? line : junk(),
                 gr, gd);
        if (!gr) cycles++;
        else got = gd;
      end
      way = !mvalid[s][0] ? 0 : (!mvalid[s][1] ? 1 : int'(mlru[s]));
      mvalid[s][way] = 1'b1;
      mtag[s][way]   = t;
      mdata[s][way]  = line;
      mlru[s]        = (way == 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles, k, lat;
    logic [31:0] got, a;
    bit h;
    logic gr;
    logic [31:0] gd;

    rst = 1'b0;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    address = 32'h0;
    wdata = 32'h0;
    sram_ready = 1'b0;
    sram_rdata = 64'h0;
    model_reset();
    #1 rst = 1'b1;
    #11;
    check("reset_ready", ready, 1'b1);
    check("reset_rd_en", sram_rd_en, 1'b0);
    check("reset_wr_en", sram_wr_en, 1'b0);
    check("reset_rdata", rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Cold read, fill, then same-line hit on the other word.
    mem[32'h10] = 32'h33334444;
    mem[32'h14] = 32'h11112222;
    access(1'b1, 1'b0, 32'h10, 32'h0, 5, cycles, got, h);
    check("cold_read_hit", h, 1'b0);
    check("cold_read_cycles", cycles, 5);
    check("cold_read_data", got, 32'h33334444);
    access(1'b1, 1'b0, 32'h14, 32'h0, 5, cycles, got, h);
    check("hit_read_cycles", cycles, 0);
    check("hit_read_data", got, 32'h11112222);

    // Write-through hit then read back.
    access(1'b0, 1'b1, 32'h10, 32'hdeadbeef, 3, cycles, got, h);
    check("write_hit_cycles", cycles, 3);
    access(1'b1, 1'b0, 32'h10, 32'h0, 3, cycles, got, h);
    check("write_readback_cycles", cycles, 0);
    check("write_readback_data", got, 32'hdeadbeef);

    // LRU eviction in set 0.
    access(1'b1, 1'b0, 32'h000, 32'h0, 2, cycles, got, h);
    access(1'b1, 1'b0, 32'h200, 32'h0, 2, cycles, got, h);
    access(1'b1, 1'b0, 32'h200, 32'h0, 2, cycles, got, h);
    check("lru_reread_cycles", cycles, 0);
    access(1'b1, 1'b0, 32'h400, 32'h0, 4, cycles, got, h);
    check("lru_evict_hit", h, 1'b0);
    check("lru_evict_cycles", cycles, 4);
    access(1'b1, 1'b0, 32'h200, 32'h0, 4, cycles, got, h);
    check("lru_kept_cycles", cycles, 0);
    access(1'b1, 1'b0, 32'h000, 32'h0, 4, cycles, got, h);
    check("lru_evicted_cycles", cycles, 4);

    // Write miss allocates nothing.
    access(1'b0, 1'b1, 32'h600, 32'h600d600d, 2, cycles, got, h);
    check("write_miss_hit", h, 1'b0);
    access(1'b1, 1'b0, 32'h600, 32'h0, 3, cycles, got, h);
    check("no_alloc_cycles", cycles, 3);
    check("no_alloc_data", got, 32'h600d600d);

    // Read and write together: write wins.
    access(1'b1, 1'b1, 32'h20, 32'hcafef00d, 2, cycles, got, h);
    check("rw_both_cycles", cycles, 2);
    access(1'b1, 1'b0, 32'h20, 32'h0, 1, cycles, got, h);
    check("rw_both_read_cycles", cycles, 1);
    check("rw_both_read_data", got, 32'hcafef00d);

    // Randomized mix over a small address pool to force conflicts.
    for (int i = 0; i < 300; i++) begin
      k   = $urandom_range(0, 99);
      lat = $urandom_range(1, 4);
      a   = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 3) | ($urandom_range(0, 1) << 2);
      if (k < 10)      idle_cycle();
      else if (k < 50) access(1'b1, 1'b0, a, 32'h0, lat, cycles, got, h);
      else if (k < 85) access(1'b0, 1'b1, a, $urandom(), lat, cycles, got, h);
      else             access(1'b1, 1'b1, a, $urandom(), lat, cycles, got, h);
    end

    // Reset in the middle of a miss.
    access(1'b1, 1'b0, 32'h80, 32'h0, 2, cycles, got, h);
    MEM_R_EN = 1'b1;
    MEM_W_EN = 1'b0;
    address  = 32'h7f000;
    cyc_step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, junk(), gr, gd);
    cyc_step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, junk(), gr, gd);
    chk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_rd_en", sram_rd_en, 1'b0);
    check("rst_mid_wr_en", sram_wr_en, 1'b0);
    MEM_R_EN = 1'b0;
    #1;
    check("rst_idle_ready", ready, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    access(1'b1, 1'b0, 32'h80, 32'h0, 3, cycles, got, h);
    check("after_rst_hit", h, 1'b0);
    check("after_rst_cycles", cycles, 3);
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_cache_controller.md
SRAM_CACHE_CONTROLLER -- requirements
Module: sram_cache_controller

Interface
REQ-001 SHALL have the following ports, one per line: name  direction  width  meaning.
  clk  input  1  single clock; all state updates on rising edge.
  rst  input  1  reset, asynchronous, active-high.
  MEM_R_EN  input  1  pipeline load request; held until ready=1.
  MEM_W_EN  input  1  pipeline store request; held until ready=1.
  address  input  32  byte address, already offset by the memory stage; only bits [18:2] used.
  wdata  input  32  store data.
  rdata  output  32  load data; valid only in the cycle ready=1 for a load.
  ready  output  1  0 = stall pipeline; 1 = request complete or no request.
  sram_rd_en  output  1  read request to SRAM controller.
  sram_wr_en  output  1  write request to SRAM controller.
  sram_address  output  32  equals address, combinational.
  sram_wdata  output  32  equals wdata, combinational.
  sram_rdata  input  64  64-bit block from SRAM controller.
  sram_ready  input  1  SRAM controller completion, combinational, high in last transfer cycle.
REQ-002 SHALL use these parameters, one per line: name, default, meaning.
  SETS, 64, number of sets.
  TAG_W, 10, tag width.

Function
REQ-003 SHALL be a 2-way set-associative cache with 64-bit lines (two 32-bit words), write-through, no-write-allocate.
REQ-004 SHALL decode address[2] = word select (0 = sram_rdata[31:0]), address[8:3] = set index, address[18:9] = tag.
REQ-005 SHALL hold per set: two valid bits, two tags, two 64-bit lines, one LRU bit naming the way to replace next.
REQ-006 SHALL implement FSM states IDLE, RD_MISS and WR_THRU, with state held in a register.
REQ-007 In IDLE, read hit SHALL drive ready=1 and rdata=hit word in the same cycle (zero wait); no SRAM request; LRU := other way.
REQ-008 In IDLE, read miss SHALL drive ready=0 and move to RD_MISS at the next edge.
REQ-009 In IDLE, any write SHALL drive ready=0 and move to WR_THRU at the next edge.
REQ-010 In IDLE with no request, ready SHALL be 1.
REQ-011 When MEM_W_EN and MEM_R_EN are both high, the write SHALL take priority and the read SHALL be ignored.
REQ-012 In RD_MISS, sram_rd_en SHALL be 1 and ready SHALL equal sram_ready.
REQ-013 In the RD_MISS cycle with sram_ready=1: rdata SHALL be the selected word of sram_rdata; the line SHALL be filled at the edge; state SHALL return to IDLE.
REQ-014 Fill way SHALL be way0 if invalid, else way1 if invalid, else the LRU way; after the fill, LRU := other way, valid := 1, tag := address tag.
REQ-015 In WR_THRU, sram_wr_en SHALL be 1 and ready SHALL equal sram_ready.
REQ-016 On the WR_THRU completion edge, a write hit SHALL update only the addressed word in the hit way and set LRU := other way; a write miss SHALL leave cache contents unchanged; state SHALL return to IDLE.
REQ-017 sram_rd_en and sram_wr_en SHALL be 0 in IDLE; they SHALL never both be 1 in the same cycle.
REQ-018 SHALL deassert each SRAM enable in the cycle after sram_ready, so the SRAM controller sequence counter restarts cleanly.
REQ-019 rdata SHALL be 0 whenever there is neither a read hit nor a completing fill.
REQ-020 Hit detection SHALL require valid=1 and a tag match; both ways matching SHALL be impossible by construction.

Reset
REQ-021 rst=1 SHALL asynchronously force state=IDLE, all valid bits=0 and all LRU bits=0; sram_rd_en and sram_wr_en SHALL drop immediately.
REQ-022 During reset, ready SHALL be 1 when no request is present; line data and tags need not be cleared.
REQ-023 Reset during RD_MISS or WR_THRU SHALL abort the transfer without filling or updating any line.

Verification
REQ-024 Cold read 0x10, SRAM model returns 0x11112222_33334444 after 5 cycles -> sram_rd_en high from cycle 1; ready=1 and rdata=0x33334444 on the sram_ready cycle; next read 0x14 -> same-cycle ready=1, rdata=0x11112222, sram_rd_en=0.
REQ-025 After REQ-024, write 0x10=0xDEADBEEF -> sram_wr_en high until sram_ready; ready is low until then; a following read 0x10 hits and returns 0xDEADBEEF.
REQ-026 Reads of 0x000, 0x200, read of 0x200 again, then read 0x400 (all set 0) -> 0x400 evicts 0x000's way; reread 0x200 hits; reread 0x000 misses.
REQ-027 Write miss to 0x600 -> SRAM written and no allocation; a subsequent read 0x600 misses and issues sram_rd_en.
REQ-028 rst pulsed mid RD_MISS -> enables are 0 in the same cycle; a later read of a previously cached address misses.
REQ-029 MEM_R_EN=MEM_W_EN=1 at address 0x20 -> only sram_wr_en is asserted; completion behaves as a write.
